trsig_nway: RTL and testbench

TRSIG_NWAY -- requirements
Module: trsig_nway

---
 rtl/trsig_pkg.sv | 21 ++
 rtl/trsig_timer.sv | 44 ++++
 rtl/trsig_nway.sv | 219 +++++++++++++++++++++
 tb/tb_trsig_nway.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trsig_pkg.sv
// trsig_pkg -- shared types and default timing for the N-way traffic signal
// controller.
//   trsig_state_e : controller phases
//   DEF_*         : default parameter values used by trsig_nway
package trsig_pkg;

  typedef enum logic [1:0] {
    ARED   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    WALK   = 2'd3
  } trsig_state_e;

  localparam int DEF_N_WAY    = 4;
  localparam int DEF_GRN_CYC  = 3;
  localparam int DEF_YEL_CYC  = 2;
  localparam int DEF_ARED_CYC = 1;
  localparam int DEF_WALK_CYC = 2;
  localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/trsig_timer.sv
// trsig_timer -- loadable down-counter used as the phase timer.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, counter goes to RST_VAL
//   en       : count/load enable; low holds the count
//   load     : load load_val instead of decrementing (qualified by en)
//   load_val : value loaded on a qualified load
//   zero     : count is zero
module trsig_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (load) begin
        cnt_d = load_val;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/trsig_nway.sv
// trsig_nway -- N-way traffic signal controller (Moore FSM, registered lamps).
// Optional pedestrian phase enabled by defining macro TRSIG_PED_EN.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (forces all-red)
//   en       : run enable; low freezes timer, state and outputs
//   veh_req  : per-approach vehicle-present level
//   red/yel/grn : per-approach lamps, exactly one lit per approach
//   cur_way  : approach owning the current or last green
//   ped_req  : (TRSIG_PED_EN) pedestrian request, latched until served
//   walk     : (TRSIG_PED_EN) walk indication during the WALK phase
//
// state  | meaning
// ARED   | all approaches red, clearance before next green (or walk)
// GREEN  | approach cur_way green, others red
// YELLOW | approach cur_way yellow, others red
// WALK   | all red, walk lamp lit (TRSIG_PED_EN only)
module trsig_nway
  import trsig_pkg::*;
#(
  parameter int N_WAY    = DEF_N_WAY,
  parameter int GRN_CYC  = DEF_GRN_CYC,
  parameter int YEL_CYC  = DEF_YEL_CYC,
  parameter int ARED_CYC = DEF_ARED_CYC,
  parameter int CNT_W    = DEF_CNT_W
`ifdef TRSIG_PED_EN
  ,
  parameter int WALK_CYC = DEF_WALK_CYC
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_WAY-1:0]         veh_req,
  output logic [N_WAY-1:0]         red,
  output logic [N_WAY-1:0]         yel,
  output logic [N_WAY-1:0]         grn,
  output logic [$clog2(N_WAY)-1:0] cur_way
`ifdef TRSIG_PED_EN
  ,
  input  logic                     ped_req,
  output logic                     walk
`endif
);

  localparam int WAY_W = $clog2(N_WAY);

  trsig_state_e     state_d, state_q;
  logic [WAY_W-1:0] way_d, way_q;
  logic [N_WAY-1:0] red_d, red_q;
  logic [N_WAY-1:0] yel_d, yel_q;
  logic [N_WAY-1:0] grn_d, grn_q;
`ifdef TRSIG_PED_EN
  logic             ped_d, ped_q;
  logic             walk_d, walk_q;
`endif

  logic             tmr_zero;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [WAY_W-1:0] nxt_way;
  logic [N_WAY-1:0] way_oh;
  logic             others_req;
  logic             rest_green;

  trsig_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (CNT_W'(ARED_CYC - 1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .zero     (tmr_zero)
  );

  // Round-robin search starting after the current way; k = N_WAY lands back
  // on way_q itself, so a lone request from the current way keeps it.
  always_comb begin
    int               idx;
    logic             found;
    logic [WAY_W-1:0] idx_w;
    found   = 1'b0;
    nxt_way = WAY_W'((int'(way_q) + 1) % N_WAY);
    for (int k = 1; k <= N_WAY; k++) begin
      idx   = (int'(way_q) + k) % N_WAY;
      idx_w = WAY_W'(idx);
      if (!found && veh_req[idx_w]) begin
        nxt_way = idx_w;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    way_oh        = '0;
    way_oh[way_q] = 1'b1;
    others_req    = |(veh_req & ~way_oh);
`ifdef TRSIG_PED_EN
    rest_green    = !others_req && !ped_q;
`else
    rest_green    = !others_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    way_d        = way_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
`ifdef TRSIG_PED_EN
    // Requests arriving during WALK are already being served.
    ped_d        = ped_q | (ped_req && (state_q != WALK));
`endif
    if (en && tmr_zero) begin
      tmr_load = 1'b1;
      unique case (state_q)
        GREEN: begin
          if (rest_green) begin
            state_d = GREEN;
          end else begin
            state_d = YELLOW;
          end
        end
        YELLOW: begin
          state_d = ARED;
        end
        ARED: begin
`ifdef TRSIG_PED_EN
          if (ped_q) begin
            state_d = WALK;
            ped_d   = 1'b0;
          end else begin
            state_d = GREEN;
            way_d   = nxt_way;
          end
`else
          state_d = GREEN;
          way_d   = nxt_way;
`endif
        end
        default: begin
          state_d = ARED;
        end
      endcase

      unique case (state_d)
        GREEN:   tmr_load_val = CNT_W'(GRN_CYC - 1);
        YELLOW:  tmr_load_val = CNT_W'(YEL_CYC - 1);
`ifdef TRSIG_PED_EN
        WALK:    tmr_load_val = CNT_W'(WALK_CYC - 1);
`endif
        default: tmr_load_val = CNT_W'(ARED_CYC - 1);
      endcase
    end
  end

  // Lamps are decoded from the next state so they change on the same edge.
  always_comb begin
    red_d = '1;
    yel_d = '0;
    grn_d = '0;
`ifdef TRSIG_PED_EN
    walk_d = 1'b0;
`endif
    unique case (state_d)
      GREEN: begin
        red_d[way_d] = 1'b0;
        grn_d[way_d] = 1'b1;
      end
      YELLOW: begin
        red_d[way_d] = 1'b0;
        yel_d[way_d] = 1'b1;
      end
`ifdef TRSIG_PED_EN
      WALK: begin
        walk_d = 1'b1;
      end
`endif
      default: begin
        red_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARED;
      way_q   <= WAY_W'(N_WAY - 1);
      red_q   <= '1;
      yel_q   <= '0;
      grn_q   <= '0;
`ifdef TRSIG_PED_EN
      ped_q   <= 1'b0;
      walk_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
`ifdef TRSIG_PED_EN
      ped_q   <= ped_d;
      walk_q  <= walk_d;
`endif
    end
  end

  assign red     = red_q;
  assign yel     = yel_q;
  assign grn     = grn_q;
  assign cur_way = way_q;
`ifdef TRSIG_PED_EN
  assign walk    = walk_q;
`endif

endmodule

// File: tb/tb_trsig_nway.sv
// tb_trsig_nway -- directed bench for trsig_nway with default parameters
// (4 ways, green 3, yellow 2, all-red 1). Pedestrian checks are built only
// when TRSIG_PED_EN is defined.
module tb_trsig_nway;

  localparam int NW = 4;
  localparam int PA = 0;  // all red (ARED or WALK)
  localparam int PG = 1;
  localparam int PY = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [NW-1:0] veh_req;
  logic [NW-1:0] red, yel, grn;
  logic [1:0]    cur_way;
`ifdef TRSIG_PED_EN
  logic          ped_req;
  logic          walk;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  trsig_nway dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .veh_req (veh_req),
    .red     (red),
    .yel     (yel),
    .grn     (grn),
    .cur_way (cur_way)
`ifdef TRSIG_PED_EN
    ,
    .ped_req (ped_req),
    .walk    (walk)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [11:0] lamps(input int ph, input int w);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    case (ph)
      PG:      lamps = {~oh, 4'b0000, oh};
      PY:      lamps = {~oh, oh, 4'b0000};
      default: lamps = {4'b1111, 4'b0000, 4'b0000};
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_lamps(input string tag, input int ph, input int w);
    chk(tag, 32'({red, yel, grn}), 32'(lamps(ph, w)));
  endtask

  // Holds reset for two edges with en high, checks the reset state, then
  // releases reset at a falling edge. The next rising edge starts green.
  task automatic do_reset(input logic [3:0] v);
    rst     = 1'b1;
    en      = 1'b1;
    veh_req = v;
`ifdef TRSIG_PED_EN
    ped_req = 1'b0;
`endif
    step(2);
    chk_lamps("reset_lamps", PA, 0);
    chk("reset_way", 32'(cur_way), 32'd3);
`ifdef TRSIG_PED_EN
    chk("reset_walk", 32'(walk), 32'd0);
`endif
    rst = 1'b0;
  endtask

  // 24 cycles: each way gets G,G,G,Y,Y,A in the given order.
  task automatic rotation(input string tag, input int w0, input int w1,
                          input int w2, input int w3);
    int ws[4];
    int ph;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    for (int i = 0; i < 24; i++) begin
      step(1);
      ph = (i % 6 < 3) ? PG : ((i % 6 < 5) ? PY : PA);
      chk_lamps(tag, ph, ws[i / 6]);
      chk({tag, "_way"}, 32'(cur_way), 32'(ws[i / 6]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    en      = 1'b1;
    veh_req = '0;
`ifdef TRSIG_PED_EN
    ped_req = 1'b0;
`endif

    // All ways requesting: full round robin, back to way 0 after 24 clocks.
    do_reset(4'b1111);
    rotation("rr_all", 0, 1, 2, 3);
    step(1);
    chk_lamps("rr_wrap", PG, 0);

    // Only ways 0 and 3 requesting.
    do_reset(4'b1001);
    rotation("rr_0_3", 0, 3, 0, 3);

    // Only way 0: rest in green, then way 2 arrives.
    do_reset(4'b0001);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk_lamps("rest_green", PG, 0);
    end
    veh_req = 4'b0101;
    step(1); chk_lamps("rest_exit_g1", PG, 0);
    step(1); chk_lamps("rest_exit_g2", PG, 0);
    step(1); chk_lamps("rest_exit_y1", PY, 0);
    step(1); chk_lamps("rest_exit_y2", PY, 0);
    step(1); chk_lamps("rest_exit_ar", PA, 0);
    chk("rest_exit_arway", 32'(cur_way), 32'd0);
    step(1); chk_lamps("rest_exit_g2w", PG, 2);
    chk("rest_exit_way", 32'(cur_way), 32'd2);

    // Freeze during second green cycle.
    do_reset(4'b1111);
    step(2);
    chk_lamps("frz_pre", PG, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_lamps("frz_hold", PG, 0);
    end
    en = 1'b1;
    step(1); chk_lamps("frz_g_last", PG, 0);
    step(1); chk_lamps("frz_y1", PY, 0);
    step(1); chk_lamps("frz_y2", PY, 0);
    step(1); chk_lamps("frz_ar", PA, 0);

    // Reset during yellow (with en low) forces all-red and restarts.
    do_reset(4'b1111);
    step(4);
    chk_lamps("rstmid_pre", PY, 0);
    rst = 1'b1;
    en  = 1'b0;
    step(1);
    chk_lamps("rstmid_lamps", PA, 0);
    chk("rstmid_way", 32'(cur_way), 32'd3);
    rst = 1'b0;
    en  = 1'b1;
    rotation("rstmid_rr", 0, 1, 2, 3);

`ifdef TRSIG_PED_EN
    // Pedestrian request during way 1 green.
    do_reset(4'b1111);
    step(7);
    chk_lamps("ped_g1", PG, 1);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    chk_lamps("ped_g1b", PG, 1);
    step(1); chk_lamps("ped_g1c", PG, 1);
    step(1); chk_lamps("ped_y1", PY, 1);
    step(1); chk_lamps("ped_y2", PY, 1);
    step(1); chk_lamps("ped_ar1", PA, 1);
    chk("ped_ar1_walk", 32'(walk), 32'd0);
    step(1); chk_lamps("ped_walk1", PA, 1);
    chk("ped_walk1_w", 32'(walk), 32'd1);
    ped_req = 1'b1;
    step(1);
    ped_req = 1'b0;
    chk_lamps("ped_walk2", PA, 1);
    chk("ped_walk2_w", 32'(walk), 32'd1);
    step(1); chk_lamps("ped_ar2", PA, 1);
    chk("ped_ar2_walk", 32'(walk), 32'd0);
    step(1); chk_lamps("ped_g2", PG, 2);
    chk("ped_g2_way", 32'(cur_way), 32'd2);
    step(5); chk_lamps("ped_ar3", PA, 2);
    chk("ped_ar3_walk", 32'(walk), 32'd0);
    step(1); chk_lamps("ped_g3", PG, 3);
    chk("ped_g3_walk", 32'(walk), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
